mode7_scanout: RTL
==================

// Module: mode7_scanout
// PURPOSE
//  VGA raster generator and pixel sink for the Mode7 renderer. Scans 640x480@60,
//  drives screen x/y into the affine texture-lookup datapath, and captures its 8-bit
//  colour after a fixed pipeline latency. Emits hsync/vsync/RGB332 delay-aligned to
//  that colour. Latches transform config (angle, scale) once per frame so a frame never tears.
// PARAMETERS
//  H_ACTIVE 640  visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48   (H_TOTAL=800)
//  V_ACTIVE 480  visible lines/frame;  V_FP 10;  V_SYNC 2;   V_BP 33   (V_TOTAL=525)
//  LAT      2    pix_en ticks from x/y out to valid color_in (1..8)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  pix_en     in   1   pixel-rate enable (1 clk pulse per pixel)
//  x          out  16  screen column to lookup datapath (registered)
//  y          out  16  screen row to lookup datapath (registered)
//  color_in   in   8   RGB332 from lookup datapath, valid LAT ticks after x/y
//  angle_in   in   16  requested rotation (0..359), any time
//  scalex_in  in   24  requested X scale, 16.8 fixed point
//  scaley_in  in   24  requested Y scale, 16.8 fixed point
//  angle      out  16  frame-stable angle to datapath
//  scalex     out  24  frame-stable X scale
//  scaley     out  24  frame-stable Y scale
//  hsync      out  1   horizontal sync, active low
//  vsync      out  1   vertical sync, active low
//  rgb        out  8   {R[2:0],G[2:0],B[1:0]}, 0 outside active video
//  active     out  1   high while rgb carries visible pixel
//  frame_start out 1   1-clk pulse when shadow config loads
// BEHAVIOUR
//  - Reset (async, rst_n=0): h_cnt=v_cnt=0, x=y=0, hsync=vsync=1, rgb=0, active=0,
//    frame_start=0, angle=0, scalex=scaley=24'h000100 (1.0), delay lines cleared.
//  - All state advances only on clk edges with pix_en=1; pix_en=0 holds everything
//    (frame_start is the exception: always 0 in a clk without pix_en).
//  - h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments on h_cnt wrap, 0..V_TOTAL-1, wraps.
//  - x<=h_cnt, y<=v_cnt each tick (x/y may exceed 639/479 in blanking; datapath gates).
//  - Raw timing from counters: act = h<640 && v<480; hs_n = !(656<=h<=751);
//    vs_n = !(490<=v<=491). act/hs_n/vs_n pass through an LAT-deep tick delay line.
//  - Output register, 1 tick after the delay line: hsync, vsync, active <= delayed;
//    rgb <= delayed act ? color_in : 8'h00. Total x/y->pins latency = LAT+1 ticks,
//    identical for sync and pixels (no skew).
//  - Shadow load: on tick where h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1, angle/scalex/
//    scaley <= *_in and frame_start=1 for that clk. Input changes at any other time have
//    no effect until the next frame boundary. angle_in >=360 is loaded as-is (not clamped).
//  - Reset mid-frame: immediate return to reset values; raster restarts at (0,0),
//    first shadow load at end of first full frame.
//  - No FSM beyond counters; widths: counters 10 bits zero-extended to 16 on x/y.
// TESTING
//  1 Reset, pix_en=1 every clk -> hsync first low at tick 656+LAT+1 from x=0, low 96 ticks;
//    line period 800 ticks; vsync low for exactly 1600 ticks (lines 490-491) per 420000.
//  2 color_in = x[7:0] fed through a LAT-tick model -> rgb on pixel col N equals N[7:0]
//    for N=0..639; rgb=0 and active=0 for cols 640..799 and rows 480..524.
//  3 pix_en asserted 1 clk in 2 -> all periods double in clk; outputs hold between enables.
//  4 angle_in 0->90 mid-frame (row 200) -> angle stays 0 until frame_start, then 90;
//    frame_start exactly one pulse per 420000 ticks.
//  5 rst_n low at row 300 col 100 -> outputs at reset values asynchronously (before next clk);
//    after release x=y=0 and timing of test 1 repeats.
//  6 LAT=1 and LAT=8 builds -> test 2 passes; sync-to-first-pixel spacing unchanged.

Source files
------------

// File: rtl/mode7_scanout.sv
// mode7_scanout
//   VGA raster generator and pixel sink for the Mode7 renderer. Scans the
//   configured raster (640x480@60 by default), presents screen x/y to the affine
//   texture-lookup datapath, captures its RGB332 colour LAT pixel ticks later and
//   drives hsync/vsync/rgb/active aligned with that colour. Transform config is
//   latched once per frame so a frame never mixes two configurations.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   pix_en       pixel-rate enable, one clk pulse per pixel
//   x, y         registered screen column/row to the lookup datapath
//   color_in     RGB332 from the datapath, valid LAT ticks after x/y
//   angle_in     requested rotation, sampled only at the frame boundary
//   scalex_in    requested X scale (16.8 fixed point)
//   scaley_in    requested Y scale (16.8 fixed point)
//   angle        frame-stable rotation to the datapath
//   scalex       frame-stable X scale
//   scaley       frame-stable Y scale
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   rgb          {R[2:0],G[2:0],B[1:0]}, zero outside active video
//   active       high while rgb carries a visible pixel
//   frame_start  one-clk pulse on the tick that loads the shadow config

module mode7_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned LAT      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [15:0] x,
    output logic [15:0] y,
    input  logic [7:0]  color_in,
    input  logic [15:0] angle_in,
    input  logic [23:0] scalex_in,
    input  logic [23:0] scaley_in,
    output logic [15:0] angle,
    output logic [23:0] scalex,
    output logic [23:0] scaley,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  rgb,
    output logic        active,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [23:0] SCALE_ONE = 24'h000100;

    // raster counters
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;

    // datapath coordinates and timing flags sampled alongside them
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_act0;
    logic        r_hs0_n;
    logic        r_vs0_n;

    // delay lines matching the lookup datapath latency
    logic [LAT-1:0] r_act_dl;
    logic [LAT-1:0] r_hs_dl;
    logic [LAT-1:0] r_vs_dl;

    // pin registers
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic [7:0]  r_rgb;

    // shadow configuration
    logic [15:0] r_angle;
    logic [23:0] r_scalex;
    logic [23:0] r_scaley;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_end;
    logic        w_act;
    logic        w_hs_n;
    logic        w_vs_n;

    always_comb begin
        w_h_last    = (r_h_cnt == H_LAST);
        w_v_last    = (r_v_cnt == V_LAST);
        w_frame_end = w_h_last && w_v_last;
        w_act       = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
        w_hs_n      = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
        w_vs_n      = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Timing flags are registered in the same tick as x/y so the LAT-deep delay
    // line lines them up with color_in; the pin register adds the final tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_act0  <= 1'b0;
            r_hs0_n <= 1'b1;
            r_vs0_n <= 1'b1;
        end else if (pix_en) begin
            r_x     <= {6'd0, r_h_cnt};
            r_y     <= {6'd0, r_v_cnt};
            r_act0  <= w_act;
            r_hs0_n <= w_hs_n;
            r_vs0_n <= w_vs_n;
        end
    end

    // Delay lines clear to the inactive levels so no sync pulse or stale pixel
    // escapes right after reset.
    if (LAT == 1) begin : g_dl_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act_dl <= '0;
                r_hs_dl  <= '1;
                r_vs_dl  <= '1;
            end else if (pix_en) begin
                r_act_dl <= r_act0;
                r_hs_dl  <= r_hs0_n;
                r_vs_dl  <= r_vs0_n;
            end
        end
    end else begin : g_dl_multi
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act_dl <= '0;
                r_hs_dl  <= '1;
                r_vs_dl  <= '1;
            end else if (pix_en) begin
                r_act_dl <= {r_act_dl[LAT-2:0], r_act0};
                r_hs_dl  <= {r_hs_dl[LAT-2:0], r_hs0_n};
                r_vs_dl  <= {r_vs_dl[LAT-2:0], r_vs0_n};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_active <= 1'b0;
            r_rgb    <= '0;
        end else if (pix_en) begin
            r_hsync  <= r_hs_dl[LAT-1];
            r_vsync  <= r_vs_dl[LAT-1];
            r_active <= r_act_dl[LAT-1];
            r_rgb    <= r_act_dl[LAT-1] ? color_in : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_angle  <= '0;
            r_scalex <= SCALE_ONE;
            r_scaley <= SCALE_ONE;
        end else if (pix_en && w_frame_end) begin
            r_angle  <= angle_in;
            r_scalex <= scalex_in;
            r_scaley <= scaley_in;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign rgb         = r_rgb;
    assign angle       = r_angle;
    assign scalex      = r_scalex;
    assign scaley      = r_scaley;
    // high during the clk whose edge loads the shadow config
    assign frame_start = pix_en && w_frame_end;

endmodule
